// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag bit positions and sequencer state encoding shared by
// alu and alu_seq.
`default_nettype none

package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;

    localparam logic [3:0] OPC_LEGAL_MAX = 4'd7;

    localparam int FLAG_OVF  = 2;
    localparam int FLAG_NEG  = 1;
    localparam int FLAG_ZERO = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/alu.sv
// alu: combinational ALU. ADD/SUB report signed overflow, every other
// operation clears it; shifts use the low log2(BW) bits of b.
`default_nettype none

module alu
    import alu_pkg::*;
#(
    parameter int BW = 16
) (
    input  logic [3:0]    op_i,
    input  logic [BW-1:0] a_i,
    input  logic [BW-1:0] b_i,
    output logic [BW-1:0] y_o,
    output logic [2:0]    flags_o
);

    localparam int SHW = (BW > 1) ? $clog2(BW) : 1;

    logic [BW-1:0] w_sum;
    logic [BW-1:0] w_diff;
    logic          w_ovf;

    assign w_sum  = a_i + b_i;
    assign w_diff = a_i - b_i;

    always_comb begin
        y_o   = '0;
        w_ovf = 1'b0;
        case (op_i)
            OP_ADD: begin
                y_o   = w_sum;
                w_ovf = (a_i[BW-1] == b_i[BW-1]) && (w_sum[BW-1] != a_i[BW-1]);
            end
            OP_SUB: begin
                y_o   = w_diff;
                w_ovf = (a_i[BW-1] != b_i[BW-1]) && (w_diff[BW-1] != a_i[BW-1]);
            end
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            OP_NOT:  y_o = ~a_i;
            OP_SHL:  y_o = a_i << b_i[SHW-1:0];
            OP_SHR:  y_o = a_i >> b_i[SHW-1:0];
            default: y_o = '0;
        endcase
    end

    always_comb begin
        flags_o            = '0;
        flags_o[FLAG_OVF]  = w_ovf;
        flags_o[FLAG_NEG]  = y_o[BW-1];
        flags_o[FLAG_ZERO] = (y_o == '0);
    end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// alu_seq: single-command ALU sequencer with accumulator chaining.
// Flow: IDLE (accept) -> EXEC (register ALU output) -> RESP (hold until taken).
`default_nettype none

module alu_seq
    import alu_pkg::*;
#(
    parameter int BW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [3:0]    cmd_opcode,
    input  logic [BW-1:0] cmd_a,
    input  logic [BW-1:0] cmd_b,
    input  logic          cmd_chain,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [BW-1:0] rsp_result,
    output logic [2:0]    rsp_flags,
    output logic          rsp_err,
    output logic [BW-1:0] acc,
    output logic [7:0]    op_count
);

    state_e        state_q, state_d;
    logic [3:0]    opc_q, opc_d;
    logic [BW-1:0] a_q, a_d;
    logic [BW-1:0] b_q, b_d;
    logic [BW-1:0] result_q, result_d;
    logic [2:0]    flags_q, flags_d;
    logic          err_q, err_d;
    logic [BW-1:0] acc_q, acc_d;
    logic [7:0]    cnt_q, cnt_d;

    logic [BW-1:0] alu_y;
    logic [2:0]    alu_flags;
    logic          illegal;

    alu #(
        .BW (BW)
    ) u_alu (
        .op_i    (opc_q),
        .a_i     (a_q),
        .b_i     (b_q),
        .y_o     (alu_y),
        .flags_o (alu_flags)
    );

    assign illegal = (opc_q > OPC_LEGAL_MAX);

    // cmd_ready is the only output allowed to see rst combinationally.
    assign cmd_ready  = (state_q == ST_IDLE) && !rst;
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_result = result_q;
    assign rsp_flags  = flags_q;
    assign rsp_err    = err_q;
    assign acc        = acc_q;
    assign op_count   = cnt_q;

    always_comb begin
        state_d  = state_q;
        opc_d    = opc_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        flags_d  = flags_q;
        err_d    = err_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    opc_d   = cmd_opcode;
                    a_d     = cmd_chain ? acc_q : cmd_a;
                    b_d     = cmd_b;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                err_d = illegal;
                if (illegal) begin
                    result_d = '0;
                    flags_d  = '0;
                end else begin
                    result_d = alu_y;
                    flags_d  = alu_flags;
                    acc_d    = alu_y;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            opc_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            opc_q    <= opc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized commands against an arithmetic
// reference model of the ALU sequencer.
`default_nettype none

module tb_alu_seq;

    localparam int BW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    cmd_opcode;
    logic [BW-1:0] cmd_a;
    logic [BW-1:0] cmd_b;
    logic          cmd_chain;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [BW-1:0] rsp_result;
    logic [2:0]    rsp_flags;
    logic          rsp_err;
    logic [BW-1:0] acc;
    logic [7:0]    op_count;

    alu_seq #(.BW(BW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_opcode (cmd_opcode),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_chain  (cmd_chain),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .rsp_err    (rsp_err),
        .acc        (acc),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    logic [BW-1:0] acc_m;
    logic [7:0]    cnt_m;
    logic [BW-1:0] last_res;
    logic [2:0]    last_flags;
    logic          last_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference: operands treated as integers, results reduced mod 2^16.
    function automatic void model(input logic [3:0] op, input longint a, input longint b,
                                  output longint r, output logic [2:0] f, output logic e);
        longint m, sa, sb, t;
        m = 65536;
        r = 0; f = 3'b000; e = 1'b0;
        if (op > 4'd7) begin
            e = 1'b1;
            return;
        end
        sa = (a >= 32768) ? a - m : a;
        sb = (b >= 32768) ? b - m : b;
        case (op)
            4'd0: begin t = sa + sb; f[2] = (t > 32767) || (t < -32768); r = ((t % m) + m) % m; end
            4'd1: begin t = sa - sb; f[2] = (t > 32767) || (t < -32768); r = ((t % m) + m) % m; end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = (m - 1) - a;
            4'd6: r = (a * (longint'(1) << (b % 16))) % m;
            default: r = a / (longint'(1) << (b % 16));
        endcase
        f[1] = (r >= 32768);
        f[0] = (r == 0);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        check("rst_cmd_ready", cmd_ready, 0);
        @(posedge clk); #1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_result", rsp_result, 0);
        check("rst_flags", rsp_flags, 0);
        check("rst_err", rsp_err, 0);
        check("rst_acc", acc, 0);
        check("rst_count", op_count, 0);
        rst = 1'b0;
        #1;
        check("rst_fall_ready", cmd_ready, 1);
        acc_m = '0;
        cnt_m = '0;
    endtask

    task automatic run_cmd(input logic [3:0] op, input logic [BW-1:0] a, input logic [BW-1:0] b,
                           input logic chain, input int hold, input logic keep_valid);
        longint r;
        logic [2:0] f;
        logic e;
        int t;
        cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_chain = chain; cmd_valid = 1'b1;
        t = 0;
        while (!cmd_ready && t < 16) begin
            @(posedge clk); #1;
            t++;
        end
        if (!cmd_ready) begin
            check("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        model(op, chain ? longint'(acc_m) : longint'(a), longint'(b), r, f, e);
        @(posedge clk); #1;
        if (!keep_valid) begin
            cmd_valid  = 1'b0;
            cmd_a      = BW'($urandom);
            cmd_opcode = 4'($urandom);
        end
        rsp_ready = 1'($urandom);
        check("exec_rsp_valid", rsp_valid, 0);
        check("exec_cmd_ready", cmd_ready, 0);
        @(posedge clk); #1;
        if (!e) acc_m = r[BW-1:0];
        rsp_ready = 1'b0;
        check("resp_valid", rsp_valid, 1);
        check("resp_result", rsp_result, 32'(r[BW-1:0]));
        check("resp_flags", rsp_flags, f);
        check("resp_err", rsp_err, e);
        check("resp_acc", acc, acc_m);
        last_res = rsp_result; last_flags = rsp_flags; last_err = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", rsp_valid, 1);
            check("hold_result", rsp_result, 32'(r[BW-1:0]));
            check("hold_flags", rsp_flags, f);
            check("hold_cmd_ready", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        cnt_m = cnt_m + 8'd1;
        rsp_ready = 1'b0;
        check("hs_count", op_count, cnt_m);
        check("hs_rsp_valid", rsp_valid, 0);
        check("hs_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_opcode = '0; cmd_a = '0; cmd_b = '0; cmd_chain = 1'b0;
        acc_m = '0; cnt_m = '0;
        do_reset();

        run_cmd(4'd0, 16'd20, 16'd5, 1'b0, 0, 1'b0);
        check("add_result", last_res, 25);
        check("add_flags", last_flags, 3'b000);
        check("add_acc", acc, 25);
        check("add_count", op_count, 1);

        run_cmd(4'd1, 16'd5, 16'd20, 1'b0, 0, 1'b0);
        check("sub_neg_result", last_res, 16'hFFF1);
        check("sub_neg_flags", last_flags, 3'b010);
        run_cmd(4'd1, 16'd7, 16'd7, 1'b0, 0, 1'b0);
        check("sub_zero_flags", last_flags, 3'b001);

        run_cmd(4'd0, 16'd20, 16'd5, 1'b0, 0, 1'b0);
        run_cmd(4'd0, 16'hDEAD, 16'd5, 1'b1, 0, 1'b0);
        check("chain_result", last_res, 30);

        run_cmd(4'd0, 16'h7FFF, 16'd1, 1'b0, 0, 1'b0);
        check("ovf_result", last_res, 16'h8000);
        check("ovf_flags", last_flags, 3'b110);
        run_cmd(4'd9, 16'd3, 16'd4, 1'b0, 0, 1'b0);
        check("illegal_err", last_err, 1);
        check("illegal_result", last_res, 0);
        check("illegal_acc", acc, 16'h8000);

        run_cmd(4'd4, 16'h1234, 16'h00FF, 1'b0, 5, 1'b1);

        // Reset arriving while a command is in EXEC.
        cmd_opcode = 4'd0; cmd_a = 16'd100; cmd_b = 16'd1; cmd_chain = 1'b0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_exec_ready", cmd_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        acc_m = '0; cnt_m = '0;
        check("rst_exec_ready_after", cmd_ready, 1);
        check("rst_exec_acc", acc, 0);
        check("rst_exec_count", op_count, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_exec_no_rsp", rsp_valid, 0);
        end

        for (int n = 0; n < 256; n++) begin
            run_cmd(4'($urandom_range(0, 15)), BW'($urandom), BW'($urandom),
                    1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
        end
        check("count_wrap", op_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
